wb_trace_fifo: RTL and testbench
================================

# wb_trace_fifo

Synthesizable writeback trace buffer for the pipelined CPU with FPU. It snoops up to NCH register-file writeback ports, for example the integer writeback (wn/wd/ww) and the FPU writeback (e3n/e3d/e). Each cycle with at least one qualifying write is captured as one timestamped entry in a DEPTH-deep FIFO. A host side drains the entries over a valid/ready port. It replaces waveform dumping for on-board debug and for long bench runs, and adds multi-channel capture, zero-register filtering and a ring-buffer mode.

## Interface
- DW, 32, writeback data width per channel
- AW, 5, register-number width per channel
- NCH, 2, number of writeback channels (1..4)
- DEPTH, 16, FIFO entries; power of two, at least 2
- TSW, 16, timestamp width
- ZMASK, 2'b01, NCH-bit mask; for each set bit, writes to register 0 on that channel are ignored
- WRAP, 0, 0 = drop newest when full; 1 = overwrite oldest when full

Ports:
- clk  in  1  clock; all state updates on its rising edge
- clr  in  1  synchronous, active-high reset
- en  in  1  capture enable
- ch_we  in  NCH  per-channel write strobe
- ch_rn  in  NCH*AW  register numbers; channel i is at bits [i*AW +: AW]
- ch_wd  in  NCH*DW  write data; channel i is at bits [i*DW +: DW]
- rd_ready  in  1  consumer accepts the head entry
- rd_valid  out  1  FIFO is non-empty
- rd_mask  out  NCH  qualified-write mask of the head entry
- rd_rn  out  NCH*AW  head register numbers; lanes with a mask bit of 0 read as 0
- rd_wd  out  NCH*DW  head data; lanes with a mask bit of 0 read as 0
- rd_ts  out  TSW  timestamp of the head entry
- count  out  clog2(DEPTH)+1  current occupancy
- drop_cnt  out  16  lost-entry count; saturates at 16'hFFFF
- ovf  out  1  sticky; set on the first lost entry

## Operation
- Qualified write on channel i: `q[i] = en & ch_we[i] & !(ZMASK[i] & ch_rn_i == 0)`.
- Push when `|q` is true. The stored entry is {ts, q, rn lanes masked by q, wd lanes masked by q}.
- Free-running `ts` counter: 0 after clr, +1 every cycle, wraps modulo 2^TSW. An entry records the `ts` value of the cycle in which it was captured.
- Pop when `rd_valid & rd_ready`.
- Read is first-word-fall-through: the rd_* outputs always show the head entry. When the FIFO is empty, rd_mask, rd_rn, rd_wd and rd_ts are 0.
- Full, push and no pop, WRAP=0: the new entry is discarded and the FIFO is unchanged.
- Full, push and no pop, WRAP=1: the oldest entry is overwritten, head and tail both advance, and count stays at DEPTH.
- In both full cases above, drop_cnt increments (saturating) and ovf is set.
- Full, push and pop in the same cycle: normal operation in both modes; count stays at DEPTH and nothing is dropped.
- Empty, push and pop in the same cycle: there is no pop because rd_valid=0; the push proceeds.
- en=0: no captures. Popping continues normally.
- Pointers are clog2(DEPTH) bits and wrap naturally. count is tracked separately.

## Timing
- Reset (clr=1 at an edge): head, tail, count, ts, drop_cnt and ovf all go to 0; rd_valid and all rd_* outputs read 0 after that edge. Memory contents are don't-care.
- clr has priority over push and pop in the same cycle. The event in the clr cycle is lost and is not counted as a drop.
- Capture latency: a write sampled at edge N is visible on rd_* with rd_valid=1 after edge N, i.e. in cycle N+1.
- Handshake: rd_valid never deasserts without a pop or clr. While rd_ready=0, the head entry is held stable.
- Exception, WRAP=1 when full: a push with no pop replaces the head. The visible head then changes to the next-oldest entry.
- Sustained throughput: one push and one pop per cycle.
- count updates on the same edge as the push or pop.
- drop_cnt and ovf update on the edge where the loss occurs.

## Test plan
- Reset and basic capture: clr for 2 cycles, then ch_we=01, rn0=3, wd0=32'hDEADBEEF at ts=5. Required: rd_valid=1 in the next cycle with rd_mask=01, rd_rn lane0=3, wd lane0=DEADBEEF, rd_ts=5, count=1. After a pop: rd_valid=0, count=0.
- Zero filter and dual channel: ch_we=11 with rn0=0 and rn1=0 (ZMASK=01). Required: one entry with mask=10, lane1 captured, lane0 reading 0. A cycle with ch_we=01 and rn0=0 creates no entry.
- Overflow, WRAP=0: 20 consecutive pushes with rd_ready=0 and DEPTH=16. Required: count=16, drop_cnt=4, ovf=1; the drained data is pushes 1..16 in order.
- Overflow, WRAP=1: the same stimulus. Required: count=16, drop_cnt=4; the drained data is pushes 5..20 in order.
- Full with simultaneous push and pop: FIFO full, rd_ready=1, push every cycle for 10 cycles. Required: count holds at 16, drop_cnt does not change, entries drain in order.
- clr mid-operation: count=7 and ts=100 when clr is asserted together with a push. Required: next cycle count=0, rd_valid=0, ts=0, drop_cnt=0, ovf=0, and the pushed entry is absent. Also let ts wrap from 16'hFFFF to 0 and check that the captured rd_ts values are correct across the wrap.

Source files
------------

// File: rtl/wb_trace_fifo_if.sv
// Capture and drain bus of the writeback trace buffer.
// Master drives the snooped writebacks and rd_ready; slave is the buffer.
interface wb_trace_fifo_if #(
   parameter int DW    = 32,
   parameter int AW    = 5,
   parameter int NCH   = 2,
   parameter int DEPTH = 16,
   parameter int TSW   = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic              en;
   logic [NCH-1:0]    ch_we;
   logic [NCH*AW-1:0] ch_rn;
   logic [NCH*DW-1:0] ch_wd;
   logic              rd_ready;
   logic              rd_valid;
   logic [NCH-1:0]    rd_mask;
   logic [NCH*AW-1:0] rd_rn;
   logic [NCH*DW-1:0] rd_wd;
   logic [TSW-1:0]    rd_ts;
   logic [CW-1:0]     count;
   logic [15:0]       drop_cnt;
   logic              ovf;

   modport master (
      output en, ch_we, ch_rn, ch_wd, rd_ready,
      input  rd_valid, rd_mask, rd_rn, rd_wd, rd_ts, count, drop_cnt, ovf
   );

   modport slave (
      input  en, ch_we, ch_rn, ch_wd, rd_ready,
      output rd_valid, rd_mask, rd_rn, rd_wd, rd_ts, count, drop_cnt, ovf
   );
endinterface

// File: rtl/wb_trace_fifo.sv
// Writeback trace buffer: snoops NCH register-file writeback ports and queues
// one timestamped entry per cycle with a qualifying write, drained first-word-fall-through.
module wb_trace_fifo #(
    parameter int             DW    = 32,
    parameter int             AW    = 5,
    parameter int             NCH   = 2,
    parameter int             DEPTH = 16,
    parameter int             TSW   = 16,
    parameter logic [NCH-1:0] ZMASK = NCH'(1),
    parameter bit             WRAP  = 1'b0
) (
    input logic            clk,
    input logic            clr,
    wb_trace_fifo_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = TSW + NCH + NCH * AW + NCH * DW;

    logic [EW-1:0]     mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;
    logic [TSW-1:0]    ts;
    logic [15:0]       drop_cnt;
    logic              ovf;

    logic [NCH-1:0]    q;
    logic [NCH*AW-1:0] rn_m;
    logic [NCH*DW-1:0] wd_m;
    logic [EW-1:0]     entry;
    logic [EW-1:0]     head_e;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              wr;
    logic              lost;
    logic              adv_head;

    always_comb begin
        q    = '0;
        rn_m = '0;
        wd_m = '0;
        for (int i = 0; i < NCH; i++) begin
            q[i] = bus.en & bus.ch_we[i] & ~(ZMASK[i] & (bus.ch_rn[i*AW +: AW] == '0));
            if (q[i]) begin
                rn_m[i*AW +: AW] = bus.ch_rn[i*AW +: AW];
                wd_m[i*DW +: DW] = bus.ch_wd[i*DW +: DW];
            end
        end
    end

    assign entry = {ts, q, rn_m, wd_m};
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = |q;
    assign pop   = ~empty & bus.rd_ready;
    assign lost  = push & full & ~pop;
    // In ring mode a lost push still writes: it lands on the oldest slot and drags head along.
    assign wr       = push & (~full | pop | WRAP);
    assign adv_head = pop | (lost & WRAP);

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[tail] <= entry;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            ts       <= '0;
            drop_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            ts <= ts + TSW'(1);
            if (wr) begin
                tail <= tail + PW'(1);
            end
            if (adv_head) begin
                head <= head + PW'(1);
            end
            if (wr & ~adv_head) begin
                count <= count + CW'(1);
            end else if (adv_head & ~wr) begin
                count <= count - CW'(1);
            end
            if (lost) begin
                ovf <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end

    // Empty FIFO presents an all-zero head so stale memory never leaks out.
    assign head_e = empty ? '0 : mem[head];

    assign bus.rd_valid = ~empty;
    assign bus.rd_wd    = head_e[0 +: NCH*DW];
    assign bus.rd_rn    = head_e[NCH*DW +: NCH*AW];
    assign bus.rd_mask  = head_e[NCH*DW + NCH*AW +: NCH];
    assign bus.rd_ts    = head_e[NCH*DW + NCH*AW + NCH +: TSW];
    assign bus.count    = count;
    assign bus.drop_cnt = drop_cnt;
    assign bus.ovf      = ovf;
endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed bench: drives a drop-newest and a ring-mode instance with identical
// stimulus and checks both against hand-computed values.
module tb_wb_trace_fifo;
    logic clk = 1'b0;
    logic clr = 1'b0;
    int   n_pass = 0;
    int   n_chk  = 0;

    always #5 clk = ~clk;

    wb_trace_fifo_if #(.DW(32), .AW(5), .NCH(2), .DEPTH(16), .TSW(16)) bus0 ();
    wb_trace_fifo_if #(.DW(32), .AW(5), .NCH(2), .DEPTH(16), .TSW(16)) bus1 ();

    wb_trace_fifo #(.DW(32), .AW(5), .NCH(2), .DEPTH(16), .TSW(16), .ZMASK(2'b01), .WRAP(1'b0))
        dut0 (.clk(clk), .clr(clr), .bus(bus0));
    wb_trace_fifo #(.DW(32), .AW(5), .NCH(2), .DEPTH(16), .TSW(16), .ZMASK(2'b01), .WRAP(1'b1))
        dut1 (.clk(clk), .clr(clr), .bus(bus1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit e, input bit [1:0] we, input bit [4:0] r0, input bit [4:0] r1,
                         input bit [31:0] w0, input bit [31:0] w1, input bit rdy);
        bus0.en = e;  bus0.ch_we = we; bus0.ch_rn = {r1, r0}; bus0.ch_wd = {w1, w0}; bus0.rd_ready = rdy;
        bus1.en = e;  bus1.ch_we = we; bus1.ch_rn = {r1, r0}; bus1.ch_wd = {w1, w0}; bus1.rd_ready = rdy;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_both_status(input string tag, input int cnt, input int drops, input bit ov);
        chk({tag, " w0 count"}, 64'(bus0.count), 64'(cnt));
        chk({tag, " w1 count"}, 64'(bus1.count), 64'(cnt));
        chk({tag, " w0 drop"},  64'(bus0.drop_cnt), 64'(drops));
        chk({tag, " w1 drop"},  64'(bus1.drop_cnt), 64'(drops));
        chk({tag, " w0 ovf"},   64'(bus0.ovf), 64'(ov));
        chk({tag, " w1 ovf"},   64'(bus1.ovf), 64'(ov));
    endtask

    initial begin
        drive(0, 2'b00, 0, 0, 0, 0, 0);

        // Reset and basic capture
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
        chk("rst valid", 64'(bus0.rd_valid), 64'd0);
        chk("rst ts", 64'(bus0.rd_ts), 64'd0);
        chk("rst wd", bus0.rd_wd, 64'd0);
        chk_both_status("rst", 0, 0, 0);
        repeat (5) tick();
        drive(1, 2'b01, 5'd3, 5'd0, 32'hDEADBEEF, 32'd0, 0);
        tick();
        drive(0, 2'b00, 0, 0, 0, 0, 0);
        chk("cap valid", 64'(bus0.rd_valid), 64'd1);
        chk("cap mask", 64'(bus0.rd_mask), 64'h1);
        chk("cap rn", 64'(bus0.rd_rn), 64'h3);
        chk("cap wd", bus0.rd_wd, 64'h0000_0000_DEAD_BEEF);
        chk("cap ts", 64'(bus0.rd_ts), 64'd5);
        chk("cap count", 64'(bus0.count), 64'd1);
        tick();
        chk("hold valid", 64'(bus0.rd_valid), 64'd1);
        chk("hold wd", bus0.rd_wd, 64'h0000_0000_DEAD_BEEF);
        drive(0, 2'b00, 0, 0, 0, 0, 1);
        tick();
        chk("pop valid", 64'(bus0.rd_valid), 64'd0);
        chk("pop count", 64'(bus0.count), 64'd0);
        chk("pop ts zero", 64'(bus0.rd_ts), 64'd0);
        chk("pop wd zero", bus0.rd_wd, 64'd0);

        // Zero filter and dual channel; ts is 8 at this edge
        drive(1, 2'b11, 5'd0, 5'd0, 32'h1111_1111, 32'h2222_2222, 0);
        tick();
        chk("zf mask", 64'(bus0.rd_mask), 64'h2);
        chk("zf rn", 64'(bus0.rd_rn), 64'h0);
        chk("zf wd", bus0.rd_wd, 64'h2222_2222_0000_0000);
        chk("zf ts", 64'(bus0.rd_ts), 64'd8);
        drive(1, 2'b01, 5'd0, 5'd7, 32'h3333_3333, 32'h0, 0);
        tick();
        chk("zf r0 only count", 64'(bus0.count), 64'd1);
        drive(0, 2'b00, 0, 0, 0, 0, 1);
        tick();
        drive(0, 2'b11, 5'd1, 5'd2, 32'h5, 32'h6, 0);
        tick();
        chk("en0 count", 64'(bus0.count), 64'd0);
        chk("en0 valid", 64'(bus1.rd_valid), 64'd0);

        // Overflow: 20 pushes into DEPTH=16 without draining
        for (int k = 1; k <= 20; k++) begin
            drive(1, 2'b01, 5'(k), 5'd0, 32'(k), 32'd0, 0);
            tick();
        end
        drive(0, 2'b00, 0, 0, 0, 0, 0);
        chk_both_status("ovf", 16, 4, 1);
        drive(0, 2'b00, 0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            chk("ovf w0 drain", bus0.rd_wd, 64'(i + 1));
            chk("ovf w1 drain", bus1.rd_wd, 64'(i + 5));
            tick();
        end
        chk("ovf w0 empty", 64'(bus0.count), 64'd0);
        chk("ovf w1 empty", 64'(bus1.count), 64'd0);

        // Full with simultaneous push and pop
        for (int k = 0; k < 16; k++) begin
            drive(1, 2'b01, 5'd1, 5'd0, 32'(100 + k), 32'd0, 0);
            tick();
        end
        chk_both_status("full", 16, 4, 1);
        for (int j = 0; j < 10; j++) begin
            drive(1, 2'b01, 5'd1, 5'd0, 32'(200 + j), 32'd0, 1);
            chk("pp w0 head", bus0.rd_wd, 64'(100 + j));
            chk("pp w1 head", bus1.rd_wd, 64'(100 + j));
            tick();
            chk("pp w0 count", 64'(bus0.count), 64'd16);
            chk("pp w1 count", 64'(bus1.count), 64'd16);
        end
        chk_both_status("pp after", 16, 4, 1);
        drive(0, 2'b00, 0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            chk("pp w0 drain", bus0.rd_wd, (i < 6) ? 64'(110 + i) : 64'(194 + i));
            chk("pp w1 drain", bus1.rd_wd, (i < 6) ? 64'(110 + i) : 64'(194 + i));
            tick();
        end
        chk("pp empty", 64'(bus0.count), 64'd0);

        // clr mid-operation at count=7, ts=100
        drive(0, 2'b00, 0, 0, 0, 0, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (93) tick();
        for (int k = 0; k < 7; k++) begin
            drive(1, 2'b01, 5'd2, 5'd0, 32'(k), 32'd0, 0);
            tick();
        end
        chk("pre-clr count", 64'(bus0.count), 64'd7);
        chk("pre-clr w1 count", 64'(bus1.count), 64'd7);
        drive(1, 2'b01, 5'd2, 5'd0, 32'h0BAD, 32'd0, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        drive(0, 2'b00, 0, 0, 0, 0, 0);
        chk("clr valid", 64'(bus0.rd_valid), 64'd0);
        chk_both_status("clr", 0, 0, 0);
        drive(1, 2'b01, 5'd2, 5'd0, 32'h600D, 32'd0, 0);
        tick();
        chk("post-clr ts", 64'(bus0.rd_ts), 64'd0);
        chk("post-clr wd", bus0.rd_wd, 64'h600D);
        chk("post-clr count", 64'(bus0.count), 64'd1);

        // Timestamp wrap: ts is 1 now, 2 after the pop
        drive(0, 2'b00, 0, 0, 0, 0, 1);
        tick();
        drive(0, 2'b00, 0, 0, 0, 0, 0);
        repeat (65532) tick();
        for (int k = 1; k <= 3; k++) begin
            drive(1, 2'b01, 5'd4, 5'd0, 32'(k), 32'd0, 0);
            tick();
        end
        drive(0, 2'b00, 0, 0, 0, 0, 1);
        chk("wrap count", 64'(bus0.count), 64'd3);
        chk("wrap ts0", 64'(bus0.rd_ts), 64'hFFFE);
        tick();
        chk("wrap ts1", 64'(bus0.rd_ts), 64'hFFFF);
        tick();
        chk("wrap ts2", 64'(bus0.rd_ts), 64'h0000);
        chk("wrap wd2", bus0.rd_wd, 64'd3);
        chk("wrap w1 ts2", 64'(bus1.rd_ts), 64'h0000);
        tick();
        chk("wrap empty", 64'(bus0.rd_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
